// File: rtl/mult_control.sv
// mult_control: sequencing controller for the signed shift-add multiplier.
//
// Steps the X/A/B register datapath through one run: a clear of X and A,
// then N_BITS add/shift iterations. The last iteration subtracts instead of
// adding, because the multiplier's top bit carries negative weight in two's
// complement.
//
// Optional feature:
//   MULT_CTRL_SYNC_EN  when defined, run_i passes through a 2-flop
//                      synchronizer before edge detection, which adds
//                      2 cycles of start latency.
//
// Ports:
//   Clk             system clock, all state on the rising edge
//   Reset_Load_Clr  asynchronous active-high reset (FSM to IDLE, counter to 0)
//   run_i           Run button level, active-high
//   m_i             current LSB of B (multiplier bit under test)
//   clr_xa_o        clear X and A (one cycle at the start of a run)
//   add_o           load A/X with A + S
//   sub_o           load A/X with A - S (final iteration only)
//   shift_o         arithmetic right shift of X:A:B
//   busy_o          high from CLR through the last SHF
//   done_o          high in HOLD (product valid in A:B)

module mult_control #(
    parameter int unsigned N_BITS = 8
) (
    input  logic Clk,
    input  logic Reset_Load_Clr,
    input  logic run_i,
    input  logic m_i,
    output logic clr_xa_o,
    output logic add_o,
    output logic sub_o,
    output logic shift_o,
    output logic busy_o,
    output logic done_o
);

    localparam int unsigned CntW = $clog2(N_BITS);
    localparam logic [CntW-1:0] CntLast = CntW'(N_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StClr,
        StAdd,
        StShf,
        StHold
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            run_s;
    logic            run_prev_q;
    logic            run_edge;
    logic            cnt_last;

`ifdef MULT_CTRL_SYNC_EN
    logic [1:0] run_sync_q;

    always_ff @(posedge Clk or posedge Reset_Load_Clr) begin
        if (Reset_Load_Clr) begin
            run_sync_q <= '0;
        end else begin
            run_sync_q <= {run_sync_q[0], run_i};
        end
    end

    assign run_s = run_sync_q[1];
`else
    // Source is assumed to be synchronous to Clk already.
    assign run_s = run_i;
`endif

    // run_prev keeps tracking during a run, so a press held through the
    // whole run cannot retrigger once the FSM is back in IDLE.
    assign run_edge = run_s & ~run_prev_q;
    assign cnt_last = (cnt_q == CntLast);

    always_ff @(posedge Clk or posedge Reset_Load_Clr) begin
        if (Reset_Load_Clr) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            run_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            run_prev_q <= run_s;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clr_xa_o = 1'b0;
        add_o    = 1'b0;
        sub_o    = 1'b0;
        shift_o  = 1'b0;
        busy_o   = 1'b0;
        done_o   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (run_edge) begin
                    state_d = StClr;
                end
            end
            StClr: begin
                clr_xa_o = 1'b1;
                busy_o   = 1'b1;
                cnt_d    = '0;
                state_d  = StAdd;
            end
            StAdd: begin
                // m_i is stable here: B only moves on a shift.
                add_o   = m_i & ~cnt_last;
                sub_o   = m_i & cnt_last;
                busy_o  = 1'b1;
                state_d = StShf;
            end
            StShf: begin
                shift_o = 1'b1;
                busy_o  = 1'b1;
                if (cnt_last) begin
                    state_d = StHold;
                end else begin
                    cnt_d   = cnt_q + CntW'(1);
                    state_d = StAdd;
                end
            end
            StHold: begin
                done_o = 1'b1;
                if (!run_s) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_mult_control.sv
// Self-checking bench for mult_control: randomized run/m_i stimulus compared
// cycle by cycle against a timeline model built from run start times.
module tb_mult_control;

    localparam int N = 8;
`ifdef MULT_CTRL_SYNC_EN
    localparam int Lat = 2;
`else
    localparam int Lat = 0;
`endif

    logic Clk = 1'b0;
    logic Reset_Load_Clr = 1'b1;
    logic run_i = 1'b1;
    logic m_i = 1'b0;
    logic clr_xa_o, add_o, sub_o, shift_o, busy_o, done_o;
    logic [5:0] outs;

    int checks = 0;
    int errors = 0;

    // Reference model: run history since reset, start edge of the current run.
    bit hist[$];
    int t = 0;
    int t0 = 0;
    bit active = 1'b0;

    mult_control #(.N_BITS(N)) dut (
        .Clk            (Clk),
        .Reset_Load_Clr (Reset_Load_Clr),
        .run_i          (run_i),
        .m_i            (m_i),
        .clr_xa_o       (clr_xa_o),
        .add_o          (add_o),
        .sub_o          (sub_o),
        .shift_o        (shift_o),
        .busy_o         (busy_o),
        .done_o         (done_o)
    );

    always #5 Clk = ~Clk;

    assign outs = {clr_xa_o, add_o, sub_o, shift_o, busy_o, done_o};

    task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s (t=%0d): got %b expected %b", tag, t, got, exp);
        end
    endtask

    // Run level as seen by the edge detector at edge k.
    function automatic bit run_s_at(int k);
        if (k - Lat < 0 || k - Lat >= hist.size()) return 1'b0;
        return hist[k - Lat];
    endfunction

    // Expected {clr, add, sub, shift, busy, done} in the cycle before edge t.
    function automatic logic [5:0] model_out(logic m);
        int p;
        int i;
        logic [5:0] e;
        e = '0;
        if (active) begin
            p = t - t0;
            if (p == 1) e = 6'b100010;
            else if (p >= 2 && p <= 2 * N && p % 2 == 0) begin
                i = (p - 2) / 2;
                e = {1'b0, m & (i != N - 1), m & (i == N - 1), 1'b0, 1'b1, 1'b0};
            end else if (p >= 3 && p <= 2 * N + 1) e = 6'b000110;
            else if (p >= 2 * N + 2) e = 6'b000001;
        end
        return e;
    endfunction

    function automatic void model_edge();
        bit rs;
        bit rp;
        rs = run_s_at(t);
        rp = run_s_at(t - 1);
        if (!active) begin
            if (rs && !rp) begin
                active = 1'b1;
                t0 = t;
            end
        end else if (t - t0 >= 2 * N + 2 && !rs) begin
            active = 1'b0;
        end
    endfunction

    task automatic step(input logic run, input logic m);
        @(negedge Clk);
        run_i = run;
        m_i = m;
        hist.push_back(run);
        #1;
        check("cycle", outs, model_out(m));
        check("excl", {5'd0, ($countones(outs[5:2]) <= 1)}, 6'd1);
        model_edge();
        t++;
    endtask

    task automatic do_reset(input int cycles, input logic run_during, input logic run_after);
        @(negedge Clk);
        #2;
        Reset_Load_Clr = 1'b1;
        run_i = run_during;
        #1;
        check("rst_now", outs, 6'd0);
        repeat (cycles) begin
            @(negedge Clk);
            check("rst_hold", outs, 6'd0);
        end
        run_i = run_after;
        @(posedge Clk);
        #1;
        Reset_Load_Clr = 1'b0;
        hist.delete();
        t = 0;
        active = 1'b0;
    endtask

    task automatic press_run(input int hold, input int after, input int mmode);
        // mmode: 0 = m low, 1 = m high, 2 = random
        logic m;
        for (int i = 0; i < hold + after; i++) begin
            m = (mmode == 2) ? logic'($urandom_range(0, 1)) : logic'(mmode);
            step(i < hold, m);
        end
    endtask

    initial begin
        logic run;
        // Long reset with run held, released before deassert: no activity.
        do_reset(20, 1'b1, 1'b0);
        press_run(0, 10, 2);

        // One-cycle press, m high: adds then a single final subtract.
        press_run(1, 2 * N + 6 + Lat, 1);
        // m low: no add/sub, shifts only.
        press_run(1, 2 * N + 6 + Lat, 0);

        // Hold through HOLD, then release and press again.
        press_run(2 * N + 30, 3, 2);
        press_run(1, 2 * N + 6 + Lat, 2);

        // Reset in cycle 9 of a run, then a full fresh run.
        press_run(1, 8 + Lat, 1);
        do_reset(2, 1'b0, 1'b0);
        press_run(1, 2 * N + 6 + Lat, 1);

        // A press held through reset starts a run once reset drops.
        do_reset(3, 1'b1, 1'b1);
        press_run(3, 2 * N + 6 + Lat, 2);

        // Random button activity and multiplier bits.
        run = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) run = ~run;
            step(run, logic'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
